// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Ports:
//   clk_i, arst_i         clock, async active-high reset
//   req_valid_i/data_i    producer beats, slice k = producer k
//   req_ready_o           handshake back to producers
//   grant_o               one-hot current burst owner, 0 when idle
//   fifo_usedw_i          FIFO fill level
//   fifo_wrreq_o/data_o   registered FIFO write port
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 12,
  parameter int BURST_LEN = 4
) (
  input  logic                    clk_i,
  input  logic                    arst_i,
  input  logic [N_REQ-1:0]        req_valid_i,
  input  logic [N_REQ*DWIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]        req_ready_o,
  output logic [N_REQ-1:0]        grant_o,
  input  logic [AWIDTH:0]         fifo_usedw_i,
  output logic                    fifo_wrreq_o,
  output logic [DWIDTH-1:0]       fifo_data_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [AWIDTH+1:0] DEPTH =
    {2'b01, {AWIDTH{1'b0}}};

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   next_ptr;
  logic            pick_vld;
  logic [7:0]      beat_cnt;
  logic [AWIDTH+1:0] fill;
  logic            room;
  logic            own_valid;
  logic            accept;
  logic            last_beat;
  logic            leave;
  logic [DWIDTH-1:0] own_data;
  int              j;

  // The write registered last cycle is not yet in usedw,
  // so count it as already occupying a slot.
  assign fill = {1'b0, fifo_usedw_i}
              + {{(AWIDTH+1){1'b0}}, fifo_wrreq_o};
  assign room = fill < DEPTH;

  assign own_valid = req_valid_i[owner];
  assign accept    = (state == BURST) && own_valid && room;
  assign last_beat = beat_cnt == 8'(BURST_LEN - 1);
  assign leave     = !own_valid || (accept && last_beat);
  assign next_ptr  = (owner == IW'(N_REQ - 1))
                   ? '0 : owner + 1'b1;

  always_comb begin
    own_data = '0;
    for (int k = 0; k < N_REQ; k++)
      if (IW'(k) == owner)
        own_data = req_data_i[k*DWIDTH +: DWIDTH];
  end

  always_comb begin
    req_ready_o = '0;
    if (state == BURST)
      req_ready_o[owner] = room;
  end

  // Scan downward so the lowest offset from rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    cand     = rr_ptr;
    j        = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j    = (int'(rr_ptr) + i) % N_REQ;
      cand = IW'(j);
      if (req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state        <= IDLE;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      grant_o      <= '0;
      fifo_wrreq_o <= 1'b0;
      fifo_data_o  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          fifo_wrreq_o <= 1'b0;
          if (pick_vld) begin
            owner    <= pick_idx;
            grant_o  <= N_REQ'(1) << pick_idx;
            beat_cnt <= '0;
            state    <= BURST;
          end
        end
        BURST: begin
          fifo_wrreq_o <= accept;
          if (accept) begin
            fifo_data_o <= own_data;
            beat_cnt    <= beat_cnt + 8'd1;
          end
          if (leave) begin
            state   <= IDLE;
            rr_ptr  <= next_ptr;
            grant_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a small FIFO fill model.
// Depth-4 FIFO (AWIDTH=2) so backpressure is reachable.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        arst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic [2:0]  usedw;
  logic        wrreq;
  logic [7:0]  wdata;

  int checks = 0;
  int errors = 0;

  logic [7:0] pmem [4][16];
  int         phead [4];
  int         ptail [4];
  logic [3:0] en = '0;

  logic [2:0] count;
  logic       drain = 0, drain_req = 0;
  logic       rd_pulse = 0, rd_req = 0;
  logic       ovr_en = 0, ovr_req = 0;
  logic [2:0] ovr_val = 3'd4;
  logic       rd_do;
  logic [7:0] wlog [$];
  int         viol = 0;

  logic [3:0] cur_g, cur_a, cur_r;
  logic [3:0] g [64];
  logic [3:0] a [64];
  logic [3:0] r [64];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ(4), .DWIDTH(8), .AWIDTH(2), .BURST_LEN(4)
  ) dut (
    .clk_i       (clk),
    .arst_i      (arst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .grant_o     (grant),
    .fifo_usedw_i(usedw),
    .fifo_wrreq_o(wrreq),
    .fifo_data_o (wdata)
  );

  assign usedw = ovr_en ? ovr_val : count;
  assign rd_do = (drain | rd_pulse) && (count != 3'd0);

  always @(posedge clk or posedge arst)
    if (arst) count <= 3'd0;
    else count <= count + 3'(wrreq && count < 3'd4)
                        - 3'(rd_do);

  always @(posedge clk)
    if (!arst && wrreq) begin
      wlog.push_back(wdata);
      if (count == 3'd4) viol <= viol + 1;
    end

  task automatic push(input int k, input logic [7:0] d);
    pmem[k][ptail[k]] = d;
    ptail[k]++;
  endtask

  task automatic clear_q();
    for (int k = 0; k < 4; k++) begin
      phead[k] = 0;
      ptail[k] = 0;
    end
  endtask

  task automatic do_reset();
    arst = 1'b1;
    en = '0;
    drain_req = 0; rd_req = 0; ovr_req = 0;
    drain = 0; rd_pulse = 0; ovr_en = 0;
    req_valid = '0;
    clear_q();
    @(negedge clk);
    @(negedge clk);
    wlog.delete();
    arst = 1'b0;
  endtask

  task automatic step(input int c);
    @(negedge clk);
    drain    = drain_req;
    rd_pulse = rd_req;
    ovr_en   = ovr_req;
    for (int k = 0; k < 4; k++) begin
      if (en[k] && phead[k] < ptail[k]) begin
        req_valid[k] = 1'b1;
        req_data[k*8 +: 8] = pmem[k][phead[k]];
      end else begin
        req_valid[k] = 1'b0;
      end
    end
    #1;
    cur_g = grant;
    cur_r = req_ready;
    cur_a = req_valid & req_ready;
    for (int k = 0; k < 4; k++)
      if (cur_a[k]) phead[k]++;
    g[c] = cur_g;
    a[c] = cur_a;
    r[c] = cur_r;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (grant !== 4'b0) begin
      errors++;
      $display("FAIL reset_grant: got %b expected 0000", grant);
    end
    checks++;
    if (req_ready !== 4'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0000", req_ready);
    end
    checks++;
    if (wrreq !== 1'b0) begin
      errors++;
      $display("FAIL reset_wrreq: got %b expected 0", wrreq);
    end
    checks++;
    if (wdata !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h expected 00", wdata);
    end
  endtask

  task automatic test_single();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 8; i++) push(2, 8'h10 + 8'(i));
    en = 4'b0100;
    drain_req = 1;
    for (int c = 1; c <= 14; c++) step(c);
    checks++;
    if (g[1] !== 4'b0000 || g[2] !== 4'b0100) begin
      errors++;
      $display("FAIL single_grant: got %b,%b expected 0000,0100",
               g[1], g[2]);
    end
    checks++;
    if ({a[2], a[3], a[4], a[5]} !== 16'h4444) begin
      errors++;
      $display("FAIL single_burst1: got %h expected 4444",
               {a[2], a[3], a[4], a[5]});
    end
    checks++;
    if (g[6] !== 4'b0 || r[6] !== 4'b0) begin
      errors++;
      $display("FAIL single_bubble: got g=%b r=%b expected 0,0",
               g[6], r[6]);
    end
    checks++;
    if ({g[7], a[7], a[8], a[9], a[10], g[11]} !== 24'h444440) begin
      errors++;
      $display("FAIL single_burst2: got %h expected 444440",
               {g[7], a[7], a[8], a[9], a[10], g[11]});
    end
    checks++;
    if (wlog.size() != 8) begin
      errors++;
      $display("FAIL single_wcount: got %0d expected 8", wlog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp = 8'h10 + 8'(i);
        checks++;
        if (wlog[i] !== exp) begin
          errors++;
          $display("FAIL single_data%0d: got %h expected %h",
                   i, wlog[i], exp);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp;
    logic [3:0] eg [5];
    int         gi;
    do_reset();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < 8; i++)
        push(k, 8'(k * 16 + i));
    en = 4'b1111;
    drain_req = 1;
    for (int c = 1; c <= 25; c++) step(c);
    en = 4'b0000;
    for (int c = 26; c <= 29; c++) step(c);
    eg[0] = 4'b0001; eg[1] = 4'b0010; eg[2] = 4'b0100;
    eg[3] = 4'b1000; eg[4] = 4'b0001;
    for (int b = 0; b < 5; b++) begin
      gi = 2 + 5 * b;
      checks++;
      if (g[gi] !== eg[b] || a[gi+3] !== eg[b]
          || g[gi+4] !== 4'b0) begin
        errors++;
        $display("FAIL rr_grant%0d: got g=%b a=%b end=%b expected %b",
                 b, g[gi], a[gi+3], g[gi+4], eg[b]);
      end
    end
    checks++;
    if (wlog.size() != 20) begin
      errors++;
      $display("FAIL rr_wcount: got %0d expected 20", wlog.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        exp = (i < 16) ? 8'((i / 4) * 16 + i % 4) : 8'(i - 16 + 4);
        checks++;
        if (wlog[i] !== exp) begin
          errors++;
          $display("FAIL rr_data%0d: got %h expected %h",
                   i, wlog[i], exp);
        end
      end
    end
  endtask

  task automatic test_early_release();
    logic [7:0] exp [5];
    do_reset();
    push(1, 8'hA0); push(1, 8'hA1);
    push(0, 8'hB0);
    push(3, 8'hC0); push(3, 8'hC1);
    en = 4'b0010;
    drain_req = 1;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) en = 4'b1011;
      step(c);
    end
    checks++;
    if ({g[2], a[2], a[3], a[4]} !== 16'h2220) begin
      errors++;
      $display("FAIL early_burst: got %h expected 2220",
               {g[2], a[2], a[3], a[4]});
    end
    checks++;
    if (g[5] !== 4'b0 || g[6] !== 4'b1000) begin
      errors++;
      $display("FAIL early_next: got %b,%b expected 0000,1000",
               g[5], g[6]);
    end
    checks++;
    if (g[10] !== 4'b0001) begin
      errors++;
      $display("FAIL early_third: got %b expected 0001", g[10]);
    end
    exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hC0;
    exp[3] = 8'hC1; exp[4] = 8'hB0;
    checks++;
    if (wlog.size() != 5) begin
      errors++;
      $display("FAIL early_wcount: got %0d expected 5", wlog.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wlog[i] !== exp[i]) begin
          errors++;
          $display("FAIL early_data%0d: got %h expected %h",
                   i, wlog[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int         nacc;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 6; i++) push(0, 8'h50 + 8'(i));
    en = 4'b0001;
    for (int c = 1; c <= 22; c++) begin
      rd_req = (c == 11);
      if (c == 14) drain_req = 1;
      step(c);
    end
    nacc = 0;
    for (int c = 1; c <= 11; c++) if (a[c][0]) nacc++;
    checks++;
    if (nacc != 4) begin
      errors++;
      $display("FAIL bp_writes: got %0d expected 4", nacc);
    end
    checks++;
    if ({r[7], r[8], r[9], r[10], r[11]} !== 20'h0) begin
      errors++;
      $display("FAIL bp_stall_ready: got %h expected 00000",
               {r[7], r[8], r[9], r[10], r[11]});
    end
    checks++;
    if (g[7] !== 4'b0001 || g[11] !== 4'b0001) begin
      errors++;
      $display("FAIL bp_grant: got %b,%b expected 0001",
               g[7], g[11]);
    end
    checks++;
    if (r[12] !== 4'b0001 || r[13] !== 4'b0000) begin
      errors++;
      $display("FAIL bp_resume: got %b,%b expected 0001,0000",
               r[12], r[13]);
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bp_full_write: got %0d expected 0", viol);
    end
    checks++;
    if (wlog.size() != 6) begin
      errors++;
      $display("FAIL bp_wcount: got %0d expected 6", wlog.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        exp = 8'h50 + 8'(i);
        checks++;
        if (wlog[i] !== exp) begin
          errors++;
          $display("FAIL bp_data%0d: got %h expected %h",
                   i, wlog[i], exp);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic       held;
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) push(1, 8'h60 + 8'(i));
    en = 4'b0010;
    drain_req = 1;
    for (int c = 1; c <= 14; c++) begin
      ovr_req = (c >= 3 && c <= 7);
      step(c);
    end
    held = 1'b1;
    for (int c = 3; c <= 7; c++)
      if (g[c] !== 4'b0010 || r[c] !== 4'b0000) held = 1'b0;
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold: got %b expected 1", held);
    end
    checks++;
    if ({a[2], a[8], a[9], a[10], g[11]} !== 20'h22220) begin
      errors++;
      $display("FAIL stall_beats: got %h expected 22220",
               {a[2], a[8], a[9], a[10], g[11]});
    end
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL stall_wcount: got %0d expected 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = 8'h60 + 8'(i);
        checks++;
        if (wlog[i] !== exp) begin
          errors++;
          $display("FAIL stall_data%0d: got %h expected %h",
                   i, wlog[i], exp);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(1, 8'h80 + 8'(i));
      push(2, 8'h90 + 8'(i));
    end
    en = 4'b0110;
    drain_req = 1;
    for (int c = 1; c <= 8; c++) step(c);
    checks++;
    if (g[8] !== 4'b0100 || wrreq !== 1'b1) begin
      errors++;
      $display("FAIL ar_before: got g=%b w=%b expected 0100,1",
               g[8], wrreq);
    end
    #1;
    arst = 1'b1;
    req_valid = '0;
    #1;
    checks++;
    if ({grant, req_ready} !== 8'h00) begin
      errors++;
      $display("FAIL ar_grant_ready: got %h expected 00",
               {grant, req_ready});
    end
    checks++;
    if (wrreq !== 1'b0 || wdata !== 8'h00) begin
      errors++;
      $display("FAIL ar_write: got w=%b d=%h expected 0,00",
               wrreq, wdata);
    end
    clear_q();
    for (int k = 0; k < 4; k++) push(k, 8'hE0 + 8'(k));
    en = 4'b1111;
    @(negedge clk);
    arst = 1'b0;
    for (int c = 10; c <= 11; c++) step(c);
    checks++;
    if (g[10] !== 4'b0000 || g[11] !== 4'b0001) begin
      errors++;
      $display("FAIL ar_restart: got %b,%b expected 0000,0001",
               g[10], g[11]);
    end
    for (int c = 12; c <= 30; c++) step(c);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      phead[k] = 0;
      ptail[k] = 0;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_early_release();
    test_backpressure();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares one single-clock `fifo` write port between N_REQ independent producers. Each producer offers beats through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and forwards accepted beats as registered `wrreq`/`data` to the FIFO. It throttles on the FIFO's `usedw` so that no write is ever issued to a full FIFO, despite the registered write path.

## Interface
- `N_REQ`, 4: number of producers, 2..16.
- `DWIDTH`, 8: beat width; matches the FIFO `DWIDTH`.
- `AWIDTH`, 12: FIFO address width; FIFO depth is 2**AWIDTH.
- `BURST_LEN`, 4: maximum beats per grant, 1..255.
- `clk_i` in 1: single clock; all logic is on the rising edge.
- `arst_i` in 1: reset, asynchronous and active-high.
- `req_valid_i` in N_REQ: producer k has a beat on slice k.
- `req_data_i` in N_REQ*DWIDTH: producer k data on bits [k*DWIDTH +: DWIDTH].
- `req_ready_o` out N_REQ: beat k accepted this cycle when `req_valid_i[k] & req_ready_o[k]`.
- `grant_o` out N_REQ: one-hot current owner; all zero when idle.
- `fifo_usedw_i` in AWIDTH+1: FIFO `usedw` output.
- `fifo_wrreq_o` out 1: FIFO write request, registered.
- `fifo_data_o` out DWIDTH: FIFO write data, registered.

## Operation
- State machine with two states:
  - IDLE: `req_ready_o` = 0.
    - If any `req_valid_i` bit is set, pick the first set index scanning upward from `rr_ptr`, wrapping modulo N_REQ.
    - Register that index as the owner, set `grant_o`, clear `beat_cnt`, and go to BURST.
  - BURST: `req_ready_o[owner]` = `room`; every other ready bit is 0.
    - `room` = (`fifo_usedw_i` + `fifo_wrreq_o`) < 2**AWIDTH. Compute the sum at AWIDTH+2 bits, with no wrap.
    - Accepted beat: `fifo_wrreq_o` <= 1 and `fifo_data_o` <= the owner slice on the next edge; `beat_cnt` increments.
    - Any other cycle: `fifo_wrreq_o` <= 0 and `fifo_data_o` holds its value.
- Exit BURST to IDLE when either of these happens:
  - a beat is accepted with `beat_cnt` == BURST_LEN-1;
  - `req_valid_i[owner]` is 0 in a BURST cycle.
- On exit, `rr_ptr` <= (owner+1) mod N_REQ and `grant_o` <= 0.
- A stall for lack of room does not count toward the burst and does not end it.
- Valid rising on a non-owner during BURST has no effect until the next IDLE.
- `room` accounts for the one write in flight: a beat accepted at cycle t shows up in `usedw` at t+2.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `beat_cnt` 0, `grant_o` 0, `req_ready_o` 0, `fifo_wrreq_o` 0, `fifo_data_o` 0.
- Reset asserted mid-burst clears everything at once, and the in-flight `fifo_wrreq_o` is dropped.
- Arbitration bubble: 1 cycle in IDLE between bursts.
- Best-case throughput is BURST_LEN beats per BURST_LEN+1 cycles.
- Acceptance to `fifo_wrreq_o` high: 1 cycle.
- `req_ready_o` depends combinationally on state, `fifo_usedw_i` and `fifo_wrreq_o`, and never on `req_valid_i`.
- `grant_o` changes only on IDLE to BURST and BURST to IDLE transitions.
- Fairness: a continuously valid producer is granted within N_REQ-1 other bursts.
- Invariant: the FIFO never receives a write while its `usedw` is 2**AWIDTH.

## Test plan
- Single producer:
  - stimulus: reset, then producer 2 holds valid with data 0x10..0x17, BURST_LEN=4, FIFO empty;
  - response: `grant_o`=4'b0100 one cycle after valid; 4 beats 0x10..0x13 written back-to-back; one IDLE cycle; second grant writes 0x14..0x17.
- Round robin:
  - stimulus: all 4 producers valid continuously;
  - response: grant order 0,1,2,3,0; each grant lasts 4 accepted beats; FIFO contents are grouped by producer in that order.
- Early release:
  - stimulus: producer 1 offers 2 beats, then drops valid while producers 0 and 3 are valid;
  - response: the burst ends after 2 beats; next grant is producer 3, because `rr_ptr`=2 scans 2,3.
- Backpressure at full (AWIDTH=2, depth 4):
  - stimulus: producer 0 offers 6 beats with no reads;
  - response: exactly 4 writes; `req_ready_o` drops when `usedw`+`wrreq`=4; resumes one cycle after a FIFO read lowers `usedw` to 3; no write while `usedw`=4.
- Stall inside burst:
  - stimulus: room is lost after beat 1 of 4 and returns 5 cycles later;
  - response: the grant is held throughout; the remaining 3 beats are accepted afterwards; `beat_cnt` is not advanced during the stall.
- Async reset mid-burst:
  - stimulus: assert `arst_i` between edges during beat 2;
  - response: all outputs are 0 immediately; after release the next grant starts from producer 0.
